// File: rtl/bsg_cache_dma_arb_pkg.sv
// Shared types and sizing helpers for the cache/prefetcher DMA arbiter.
package bsg_cache_dma_arb_pkg;

  typedef enum logic {WIdle, WData} wr_state_e;

  // DMA packet layout is {write_not_read, addr, mask}, one mask bit per word.
  function automatic int unsigned dma_pkt_width(int unsigned addr_width,
                                                int unsigned block_size_in_words);
    return 1 + addr_width + block_size_in_words;
  endfunction

  function automatic int unsigned safe_clog2(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bsg_cache_dma_arb_fifo.sv
// Small 1r1w FIFO recording which requester owns each outstanding read burst.
module bsg_cache_dma_arb_fifo
  import bsg_cache_dma_arb_pkg::*;
#(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 1
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = safe_clog2(Depth);
  localparam int unsigned CntW = safe_clog2(Depth + 1);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(Depth - 1);
  localparam logic [CntW-1:0] CntFull = CntW'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + 1'b1;
    if (pop_i)  rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + 1'b1;
    unique case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == CntFull);
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/bsg_cache_dma_arb.sv
// Shares one memory DMA link between the miss engine (0, demand) and prefetcher (1),
// with a starvation bound for the prefetcher and in-order routing of fill bursts.
module bsg_cache_dma_arb
  import bsg_cache_dma_arb_pkg::*;
#(
  parameter int unsigned addr_width_p          = 32,
  parameter int unsigned block_size_in_words_p = 8,
  parameter int unsigned dma_data_width_p      = 32,
  parameter int unsigned burst_len_p           = 4,
  parameter int unsigned max_reads_p           = 4,
  parameter int unsigned starve_limit_p        = 8,
  localparam int unsigned PktWidth = dma_pkt_width(addr_width_p, block_size_in_words_p)
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  input  logic [2*PktWidth-1:0]         req_dma_pkt_i,
  input  logic [1:0]                    req_dma_pkt_v_i,
  output logic [1:0]                    req_dma_pkt_yumi_o,
  output logic [2*dma_data_width_p-1:0] req_dma_data_o,
  output logic [1:0]                    req_dma_data_v_o,
  input  logic [1:0]                    req_dma_data_ready_and_i,
  input  logic [2*dma_data_width_p-1:0] req_dma_data_i,
  input  logic [1:0]                    req_dma_data_v_i,
  output logic [1:0]                    req_dma_data_yumi_o,
  output logic [PktWidth-1:0]           mem_dma_pkt_o,
  output logic                          mem_dma_pkt_v_o,
  input  logic                          mem_dma_pkt_yumi_i,
  input  logic [dma_data_width_p-1:0]   mem_dma_data_i,
  input  logic                          mem_dma_data_v_i,
  output logic                          mem_dma_data_ready_and_o,
  output logic [dma_data_width_p-1:0]   mem_dma_data_o,
  output logic                          mem_dma_data_v_o,
  input  logic                          mem_dma_data_yumi_i
);

  localparam int unsigned DW   = dma_data_width_p;
  localparam int unsigned CntW = safe_clog2(burst_len_p);
  localparam int unsigned StW  = safe_clog2(starve_limit_p + 1);
  localparam logic [CntW-1:0] LastBeat  = CntW'(burst_len_p - 1);
  localparam logic [StW-1:0]  StarveMax = StW'(starve_limit_p);

  logic [PktWidth-1:0] pkt [2];
  logic [1:0]          is_write, elig, grant;
  logic                force1, pkt_accept, win_write, win_id;
  logic                fifo_full, fifo_empty, fifo_head, fifo_push, fifo_pop;
  logic                fill_ready, fill_beat, in_wdata, evict_beat;
  wr_state_e           wr_state_q, wr_state_d;
  logic                wr_owner_q, wr_owner_d;
  logic [CntW-1:0]     rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
  logic [StW-1:0]      starve_cnt_q, starve_cnt_d;

  assign pkt[0] = req_dma_pkt_i[0 +: PktWidth];
  assign pkt[1] = req_dma_pkt_i[PktWidth +: PktWidth];

  // Eligibility uses only registered state so grant never depends on a same-cycle pop.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      is_write[i] = pkt[i][PktWidth-1];
      elig[i]     = req_dma_pkt_v_i[i] & (is_write[i] ? (wr_state_q == WIdle) : ~fifo_full);
    end
  end

  assign force1     = elig[1] & (starve_cnt_q == StarveMax);
  assign grant[1]   = elig[1] & (~elig[0] | force1);
  assign grant[0]   = elig[0] & ~force1;
  assign win_id     = grant[1];
  assign win_write  = grant[1] ? is_write[1] : is_write[0];
  assign pkt_accept = reset_n_i & (|grant) & mem_dma_pkt_yumi_i;
  assign fifo_push  = pkt_accept & ~win_write;

  assign mem_dma_pkt_v_o    = reset_n_i & (|grant);
  assign mem_dma_pkt_o      = grant[1] ? pkt[1] : pkt[0];
  assign req_dma_pkt_yumi_o = grant & {2{reset_n_i & mem_dma_pkt_yumi_i}};

  // Fill path: head of the read-order FIFO owns the current burst.
  assign fill_ready               = reset_n_i & ~fifo_empty & req_dma_data_ready_and_i[fifo_head];
  assign mem_dma_data_ready_and_o = fill_ready;
  assign req_dma_data_o           = {2{mem_dma_data_i}};
  assign fill_beat                = mem_dma_data_v_i & fill_ready;
  assign fifo_pop                 = fill_beat & (rd_cnt_q == LastBeat);

  always_comb begin
    req_dma_data_v_o = '0;
    if (reset_n_i && !fifo_empty) req_dma_data_v_o[fifo_head] = mem_dma_data_v_i;
  end

  // Evict path: only the write-burst owner is forwarded.
  assign in_wdata         = reset_n_i & (wr_state_q == WData);
  assign mem_dma_data_v_o = in_wdata & req_dma_data_v_i[wr_owner_q];
  assign mem_dma_data_o   = wr_owner_q ? req_dma_data_i[DW +: DW] : req_dma_data_i[0 +: DW];
  assign evict_beat       = mem_dma_data_v_o & mem_dma_data_yumi_i;

  always_comb begin
    req_dma_data_yumi_o             = '0;
    req_dma_data_yumi_o[wr_owner_q] = evict_beat;
  end

  always_comb begin
    wr_state_d   = wr_state_q;
    wr_owner_d   = wr_owner_q;
    wr_cnt_d     = wr_cnt_q;
    rd_cnt_d     = rd_cnt_q;
    starve_cnt_d = starve_cnt_q;

    unique case (wr_state_q)
      WIdle: begin
        if (pkt_accept && win_write) begin
          wr_state_d = WData;
          wr_owner_d = win_id;
          wr_cnt_d   = '0;
        end
      end
      WData: begin
        if (evict_beat) begin
          if (wr_cnt_q == LastBeat) begin
            wr_state_d = WIdle;
            wr_cnt_d   = '0;
          end else begin
            wr_cnt_d = wr_cnt_q + 1'b1;
          end
        end
      end
      default: wr_state_d = WIdle;
    endcase

    if (fill_beat) rd_cnt_d = (rd_cnt_q == LastBeat) ? '0 : rd_cnt_q + 1'b1;

    if (pkt_accept) begin
      if (grant[1]) begin
        starve_cnt_d = '0;
      end else if (elig[1] && starve_cnt_q != StarveMax) begin
        starve_cnt_d = starve_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      wr_state_q   <= WIdle;
      wr_owner_q   <= 1'b0;
      wr_cnt_q     <= '0;
      rd_cnt_q     <= '0;
      starve_cnt_q <= '0;
    end else begin
      wr_state_q   <= wr_state_d;
      wr_owner_q   <= wr_owner_d;
      wr_cnt_q     <= wr_cnt_d;
      rd_cnt_q     <= rd_cnt_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  bsg_cache_dma_arb_fifo #(
    .Depth(max_reads_p),
    .Width(1)
  ) u_rd_order (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .push_i   (fifo_push),
    .data_i   (win_id),
    .pop_i    (fifo_pop),
    .data_o   (fifo_head),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty)
  );

endmodule

// File: doc/bsg_cache_dma_arb.md
# bsg_cache_dma_arb

Two-requester arbiter sharing one memory-side DMA interface between the cache miss engine (requester 0, demand) and the stream prefetcher (requester 1). Arbitrates DMA packets with demand priority plus a prefetch starvation bound. Routes returning fill beats to the requester owning the oldest outstanding read. Steers evict data from the owner of the current write burst. Sits between the cache DMA engine / prefetcher and the memory DMA link.

## Interface
- addr_width_p, none: DMA packet address width.
- block_size_in_words_p, none: words per line; sets packet mask width.
- dma_data_width_p, none: DMA beat width.
- burst_len_p, none: beats per line transfer, ≥1.
- max_reads_p, 4: outstanding read bursts tracked, ≥2.
- starve_limit_p, 8: cycles requester 1 may lose before a forced grant.
- clk_i  in  1  clock.
- reset_n_i  in  1  synchronous reset, active-low.
- req_dma_pkt_i  in  2×pkt_width  DMA packets {write_not_read, addr, mask}, per requester.
- req_dma_pkt_v_i  in  2  packet valid.
- req_dma_pkt_yumi_o  out  2  packet accepted.
- req_dma_data_o  out  2×dma_data_width_p  fill beats to requesters.
- req_dma_data_v_o  out  2  fill beat valid.
- req_dma_data_ready_and_i  in  2  requester can take a fill beat.
- req_dma_data_i  in  2×dma_data_width_p  evict beats from requesters.
- req_dma_data_v_i  in  2  evict beat valid.
- req_dma_data_yumi_o  out  2  evict beat consumed.
- mem_dma_pkt_o  out  pkt_width  granted packet.
- mem_dma_pkt_v_o  out  1  packet valid.
- mem_dma_pkt_yumi_i  in  1  memory accepted packet.
- mem_dma_data_i  in  dma_data_width_p  fill beat from memory.
- mem_dma_data_v_i  in  1  fill beat valid.
- mem_dma_data_ready_and_o  out  1  fill beat accepted.
- mem_dma_data_o  out  dma_data_width_p  evict beat to memory.
- mem_dma_data_v_o  out  1  evict beat valid.
- mem_dma_data_yumi_i  in  1  memory consumed evict beat.

## Operation
- Selection, each cycle, among eligible requesters. A requester is eligible when its pkt_v is high and one of the following holds:
  - read packet: read-order FIFO is not full (registered flag; a same-cycle pop does not unblock);
  - write packet: write FSM is in W_IDLE (registered).
- Requester 0 wins unless starve_cnt == starve_limit_p and requester 1 is eligible; then requester 1 wins.
- mem_dma_pkt_v_o = winner exists. mem_dma_pkt_o = winner packet. req_dma_pkt_yumi_o[winner] = mem_dma_pkt_yumi_i.
- starve_cnt:
  - increments, saturating, on any cycle requester 1 is eligible and a packet is accepted for requester 0;
  - clears when requester 1 is accepted.
- Read accept: push the winner id into the read-order FIFO.
- Write accept: write FSM goes W_IDLE→W_DATA, latching wr_owner and clearing wr_cnt.
- Fill path:
  - mem_dma_data_ready_and_o = FIFO nonempty & req_dma_data_ready_and_i[head].
  - req_dma_data_v_o[head] = mem_dma_data_v_i & FIFO nonempty; the other requester sees 0. Data is broadcast to both requesters.
  - Each accepted beat increments rd_cnt. On beat burst_len_p−1, rd_cnt clears and the FIFO pops.
  - Beats arriving while the FIFO is empty are not accepted.
- Evict path, in W_DATA only:
  - mem_dma_data_v_o = req_dma_data_v_i[wr_owner]; mem_dma_data_o = req_dma_data_i[wr_owner].
  - req_dma_data_yumi_o[wr_owner] = mem_dma_data_yumi_i.
  - On the burst_len_p-th consumed beat, return to W_IDLE.
  - The evict path ignores req_dma_data_v_i from the non-owner.
- Read and write traffic proceed concurrently and independently.

## Timing
- Packet arbitration is combinational: grant is in the same cycle as pkt_v.
- Fill and evict steering are combinational. Zero added latency and no buffering of data beats.
- The write FSM and FIFO update on the accepting edge. A write accept at cycle t allows evict beats from cycle t+1.
- Reset (reset_n_i low at an edge):
  - FIFO empty; rd_cnt, wr_cnt and starve_cnt = 0; FSM = W_IDLE.
  - Every v/yumi/ready output is 0 while in reset and in the first cycle after, until inputs drive them.
  - Reset mid-burst abandons all tracking; the system resets requesters and memory together.
- Simultaneous read accept and last-beat pop: both take effect; FIFO count is unchanged.
- burst_len_p == 1: every fill beat pops; W_DATA lasts exactly one consumed beat.

## Structure
- bsg_cache_pkg gains:
  - wr_state_e {W_IDLE, W_DATA};
  - the DMA packet struct macro, reused for pkt_width.
- Read-order FIFO: bsg_fifo_1r1w_small, width 1, els max_reads_p.
- rd_cnt and wr_cnt: bsg_counter_clear_up, max burst_len_p−1.
- The FSM, arbitration and starvation counter are local logic.

## Test plan
- burst_len_p=4; requester 0 read, addr 0x100, granted; 4 fill beats 0xA0..0xA3 → all to requester 0, FIFO empty after.
- Both read every cycle, starve_limit_p=8, memory always accepts → requester 1 granted exactly on the 9th cycle; starve_cnt returns to 0.
- Reads from 0, 1, 0 accepted back to back → fill bursts delivered in order 0, 1, 0. requester 1 ready_and low stalls mem_dma_data_ready_and_o with no beat lost.
- max_reads_p=2, both slots full → third read pkt_v sees no yumi until the pop edge; a write packet is still granted meanwhile.
- Requester 1 write accepted, then requester 0 write pending → requester 0 is not granted until 4 evict beats are consumed; requester 0's evict data is never forwarded early.
- reset_n_i low for one cycle mid-fill → all outputs 0, FIFO empty; a new read then completes normally.
